// File: rtl/header_word_loader_pkg.sv
// Shared types and default geometry for the header word loader.
package header_word_loader_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int BYTE_WIDTH     = 8;
    localparam int DEF_WORD_WIDTH = 32;
    localparam int DEF_WORD_COUNT = 20;
    localparam int DEF_CNT_WIDTH  = 5;

endpackage

// File: rtl/header_word_loader_if.sv
// Stream-in / header-out bus of the header word loader.
interface header_word_loader_if
    import header_word_loader_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int WORD_COUNT = DEF_WORD_COUNT
) ();

    // valid/ready: a transfer happens on a rising clk edge where valid and ready
    // are both high; the source holds valid and its payload steady until then.
    logic                           swap_en;
    logic [WORD_WIDTH-1:0]          s_data;
    logic                           s_valid;
    logic                           s_last;
    logic                           s_ready;
    logic [WORD_WIDTH*WORD_COUNT-1:0] hdr_data;
    logic                           hdr_valid;
    logic                           hdr_ready;
    logic                           err_short;
    logic                           err_long;
    logic [15:0]                    hdr_count;
    state_t                         dbg_state;

    modport slave (
        input  swap_en, s_data, s_valid, s_last, hdr_ready,
        output s_ready, hdr_data, hdr_valid, err_short, err_long, hdr_count, dbg_state
    );

    modport master (
        output swap_en, s_data, s_valid, s_last, hdr_ready,
        input  s_ready, hdr_data, hdr_valid, err_short, err_long, hdr_count, dbg_state
    );

endinterface

// File: rtl/swap_endian.sv
// Reverses the order of UNIT_WIDTH-bit units within a word.
module swap_endian #(
    parameter int UNIT_WIDTH = 8,
    parameter int UNIT_COUNT = 4
) (
    input  logic [UNIT_WIDTH*UNIT_COUNT-1:0] in_data,
    output logic [UNIT_WIDTH*UNIT_COUNT-1:0] out_data
);

    for (genvar i = 0; i < UNIT_COUNT; i++) begin : g_unit
        assign out_data[i*UNIT_WIDTH +: UNIT_WIDTH] =
            in_data[(UNIT_COUNT-1-i)*UNIT_WIDTH +: UNIT_WIDTH];
    end

endmodule

// File: rtl/header_word_loader.sv
// Packs a framed word stream into one header register, optionally byte-swapping
// each word, and hands it to the hashing core; bad frame lengths are flagged and skipped.
module header_word_loader
    import header_word_loader_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int WORD_COUNT = DEF_WORD_COUNT,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input logic                  clk,
    input logic                  rst,
    header_word_loader_if.slave  bus
);

    localparam int                   HDR_WIDTH = WORD_WIDTH * WORD_COUNT;
    localparam logic [CNT_WIDTH-1:0] LAST_CNT  = CNT_WIDTH'(WORD_COUNT - 1);

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   swap_q, swap_d;
    logic [HDR_WIDTH-1:0]   hdr_data_q, hdr_data_d;
    logic                   err_short_q, err_short_d;
    logic                   err_long_q, err_long_d;
    logic [15:0]            hdr_count_q, hdr_count_d;

    logic                   s_ready;
    logic                   accept;
    logic                   at_last;
    logic                   swap_sel;
    logic [WORD_WIDTH-1:0]  swapped_word;
    logic [WORD_WIDTH-1:0]  word;

    swap_endian #(
        .UNIT_WIDTH (BYTE_WIDTH),
        .UNIT_COUNT (WORD_WIDTH / BYTE_WIDTH)
    ) u_swap (
        .in_data  (bus.s_data),
        .out_data (swapped_word)
    );

    assign accept  = bus.s_valid && s_ready;
    assign at_last = (cnt_q == LAST_CNT);
    // The first word of a frame must honour swap_en before it is latched.
    assign swap_sel = (cnt_q == '0) ? bus.swap_en : swap_q;
    assign word     = swap_sel ? swapped_word : bus.s_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL:    if (accept && at_last) state_d = bus.s_last ? HOLD : DRAIN;
            HOLD:    if (bus.hdr_ready) state_d = FILL;
            DRAIN:   if (accept && bus.s_last) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        s_ready       = !rst && (state_q != HOLD);
        bus.s_ready   = s_ready;
        bus.hdr_valid = (state_q == HOLD);
        bus.hdr_data  = hdr_data_q;
        bus.err_short = err_short_q;
        bus.err_long  = err_long_q;
        bus.hdr_count = hdr_count_q;
        bus.dbg_state = state_q;
    end

    always_comb begin
        cnt_d       = cnt_q;
        swap_d      = swap_q;
        hdr_data_d  = hdr_data_q;
        err_short_d = 1'b0;
        err_long_d  = 1'b0;
        hdr_count_d = hdr_count_q;
        case (state_q)
            FILL: begin
                if (accept) begin
                    if (cnt_q == '0) swap_d = bus.swap_en;
                    hdr_data_d[(WORD_COUNT-1-int'(cnt_q))*WORD_WIDTH +: WORD_WIDTH] = word;
                    if (at_last) begin
                        cnt_d      = '0;
                        err_long_d = !bus.s_last;
                    end else if (bus.s_last) begin
                        // Short frame: restart; stale words stay in hdr_data until overwritten.
                        cnt_d       = '0;
                        err_short_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (bus.hdr_ready) hdr_count_d = hdr_count_q + 16'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            swap_q      <= 1'b0;
            hdr_data_q  <= '0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
            hdr_count_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            swap_q      <= swap_d;
            hdr_data_q  <= hdr_data_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
            hdr_count_q <= hdr_count_d;
        end
    end

endmodule

// File: tb/tb_header_word_loader.sv
// Bench for header_word_loader: directed frame table, corner sequences and random
// frames, all checked every cycle against a queue-based frame model.
module tb_header_word_loader;
    import header_word_loader_pkg::*;

    localparam int WW = 32;
    localparam int WC = 20;
    localparam int CW = 5;
    localparam int HW = WW * WC;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    header_word_loader_if #(.WORD_WIDTH(WW), .WORD_COUNT(WC)) bus ();

    header_word_loader #(
        .WORD_WIDTH (WW),
        .WORD_COUNT (WC),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int seen_short = 0;
    int seen_long  = 0;
    logic [15:0] deliveries = 16'd0;

    // ---------------- reference model ----------------
    logic [WW-1:0] m_words[$];
    logic [WW-1:0] m_hdr[WC];
    bit            m_holding, m_draining, m_swap, m_err_s, m_err_l;
    logic [15:0]   m_count;

    task automatic model_reset();
        m_words.delete();
        for (int i = 0; i < WC; i++) m_hdr[i] = '0;
        m_holding = 0; m_draining = 0; m_swap = 0;
        m_err_s = 0; m_err_l = 0; m_count = 16'd0;
    endtask

    task automatic model_step();
        logic [WW-1:0] w;
        if (rst) begin
            model_reset();
            return;
        end
        m_err_s = 0;
        m_err_l = 0;
        if (m_holding) begin
            if (bus.hdr_ready) begin
                m_holding = 0;
                m_count++;
            end
        end else if (bus.s_valid) begin
            if (m_draining) begin
                if (bus.s_last) m_draining = 0;
            end else begin
                if (m_words.size() == 0) m_swap = bus.swap_en;
                w = m_swap ? {<<8{bus.s_data}} : bus.s_data;
                m_hdr[m_words.size()] = w;
                m_words.push_back(w);
                if (m_words.size() == WC) begin
                    if (bus.s_last) m_holding = 1;
                    else begin m_err_l = 1; m_draining = 1; end
                    m_words.delete();
                end else if (bus.s_last) begin
                    m_err_s = 1;
                    m_words.delete();
                end
            end
        end
    endtask

    function automatic logic [HW-1:0] model_hdr();
        logic [HW-1:0] r = '0;
        for (int i = 0; i < WC; i++) r = (r << WW) | HW'(m_hdr[i]);
        return r;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_hdr(input string name, input logic [HW-1:0] act, input logic [HW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("s_ready", 64'(bus.s_ready), 64'(!rst && !m_holding));
        chk("hdr_valid", 64'(bus.hdr_valid), 64'(m_holding));
        chk("err_short", 64'(bus.err_short), 64'(m_err_s));
        chk("err_long", 64'(bus.err_long), 64'(m_err_l));
        chk("hdr_count", 64'(bus.hdr_count), 64'(m_count));
        chk_hdr("hdr_data", bus.hdr_data, model_hdr());
        if (bus.err_short === 1'b1) seen_short++;
        if (bus.err_long === 1'b1) seen_long++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    // ---------------- drivers ----------------
    task automatic wait_ready();
        int b = 0;
        while (bus.s_ready !== 1'b1 && b < 50) begin tick(); b++; end
        chk("s_ready_timeout", 64'(bus.s_ready), 64'd1);
    endtask

    task automatic drive_frame(input bit swap, input bit first_only, input int n,
                               input int gap, input logic [WW-1:0] base);
        for (int k = 0; k < n; k++) begin
            bus.s_valid   = 1'b1;
            bus.s_data    = base + WW'(k);
            bus.s_last    = (k == n - 1);
            bus.swap_en   = (first_only && k > 0) ? 1'b0 : swap;
            bus.hdr_ready = (k == n - 1) ? 1'b0 : 1'($urandom_range(0, 1));
            wait_ready();
            tick();
            if (k != n - 1) begin
                for (int g = 0; g < gap; g++) begin
                    bus.s_valid = 1'b0;
                    bus.s_data  = $urandom;
                    bus.s_last  = 1'($urandom_range(0, 1));
                    bus.swap_en = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        end
        bus.s_valid   = 1'b0;
        bus.s_last    = 1'b0;
        bus.hdr_ready = 1'b0;
    endtask

    task automatic wait_valid();
        int b = 0;
        while (bus.hdr_valid !== 1'b1 && b < 50) begin tick(); b++; end
        chk("hdr_valid_timeout", 64'(bus.hdr_valid), 64'd1);
    endtask

    task automatic consume(input int stall);
        wait_valid();
        for (int s = 0; s < stall; s++) begin
            bus.hdr_ready = 1'b0;
            tick();
            chk("hold_s_ready", 64'(bus.s_ready), 64'd0);
        end
        bus.hdr_ready = 1'b1;
        tick();
        bus.hdr_ready = 1'b0;
        deliveries++;
        chk("bubble_s_ready", 64'(bus.s_ready), 64'd1);
        chk("delivered_count", 64'(bus.hdr_count), 64'(deliveries));
    endtask

    // ---------------- directed frame table ----------------
    typedef struct {
        bit            swap;
        bit            first_only;
        int            n;
        int            gap;
        int            exp_short;
        int            exp_long;
        bit            exp_deliv;
        logic [WW-1:0] exp_first;
        logic [WW-1:0] exp_last;
    } vec_t;

    vec_t vecs[7];

    initial begin
        bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0;
        bus.swap_en = 1'b0; bus.hdr_ready = 1'b0;
        rst = 1'b1;
        model_reset();

        vecs[0] = '{swap:1, first_only:0, n:20, gap:0, exp_short:0, exp_long:0, exp_deliv:1,
                    exp_first:32'h04030201, exp_last:32'h17030201};
        vecs[1] = '{swap:0, first_only:0, n:20, gap:3, exp_short:0, exp_long:0, exp_deliv:1,
                    exp_first:32'h01020304, exp_last:32'h01020317};
        vecs[2] = '{swap:1, first_only:1, n:20, gap:1, exp_short:0, exp_long:0, exp_deliv:1,
                    exp_first:32'h04030201, exp_last:32'h17030201};
        vecs[3] = '{swap:0, first_only:0, n:6, gap:0, exp_short:1, exp_long:0, exp_deliv:0,
                    exp_first:32'h0, exp_last:32'h0};
        vecs[4] = '{swap:0, first_only:0, n:20, gap:0, exp_short:0, exp_long:0, exp_deliv:1,
                    exp_first:32'h01020304, exp_last:32'h01020317};
        vecs[5] = '{swap:1, first_only:0, n:23, gap:0, exp_short:0, exp_long:1, exp_deliv:0,
                    exp_first:32'h0, exp_last:32'h0};
        vecs[6] = '{swap:1, first_only:0, n:20, gap:2, exp_short:0, exp_long:0, exp_deliv:1,
                    exp_first:32'h04030201, exp_last:32'h17030201};

        tick();
        tick();
        chk("reset_s_ready", 64'(bus.s_ready), 64'd0);
        chk("reset_hdr_valid", 64'(bus.hdr_valid), 64'd0);
        chk_hdr("reset_hdr_data", bus.hdr_data, '0);
        rst = 1'b0;
        tick();
        chk("post_reset_s_ready", 64'(bus.s_ready), 64'd1);

        for (int v = 0; v < 7; v++) begin
            seen_short = 0;
            seen_long  = 0;
            drive_frame(vecs[v].swap, vecs[v].first_only, vecs[v].n, vecs[v].gap, 32'h01020304);
            if (vecs[v].exp_deliv) begin
                wait_valid();
                chk("vec_first_word", 64'(bus.hdr_data[HW-1 -: WW]), 64'(vecs[v].exp_first));
                chk("vec_last_word", 64'(bus.hdr_data[WW-1:0]), 64'(vecs[v].exp_last));
                consume(0);
            end else begin
                repeat (3) tick();
                chk("vec_no_valid", 64'(bus.hdr_valid), 64'd0);
                chk("vec_count_kept", 64'(bus.hdr_count), 64'(deliveries));
            end
            chk("vec_err_short_pulses", 64'(seen_short), 64'(vecs[v].exp_short));
            chk("vec_err_long_pulses", 64'(seen_long), 64'(vecs[v].exp_long));
        end

        // backpressure: header held for 10 cycles with hdr_ready low
        drive_frame(1'b0, 1'b0, 20, 0, 32'hA5A50000);
        consume(10);

        // reset in the middle of a frame
        for (int k = 0; k < 7; k++) begin
            bus.s_valid = 1'b1; bus.s_data = 32'hC0DE0000 + WW'(k);
            bus.s_last = 1'b0; bus.swap_en = 1'b1;
            wait_ready();
            tick();
        end
        bus.s_data = 32'hC0DE0007;
        rst = 1'b1;
        tick();
        tick();
        bus.s_valid = 1'b0;
        chk("midreset_s_ready", 64'(bus.s_ready), 64'd0);
        chk("midreset_count", 64'(bus.hdr_count), 64'd0);
        chk_hdr("midreset_hdr_data", bus.hdr_data, '0);
        rst = 1'b0;
        deliveries = 16'd0;
        seen_short = 0;
        tick();
        chk("midreset_ready_back", 64'(bus.s_ready), 64'd1);
        drive_frame(1'b0, 1'b0, 20, 0, 32'h11223344);
        wait_valid();
        chk("clean_first_word", 64'(bus.hdr_data[HW-1 -: WW]), 64'h11223344);
        chk("clean_no_err_short", 64'(seen_short), 64'd0);
        consume(2);

        // hdr_count wrap: preload near the top
        force dut.hdr_count_q = 16'hFFFE;
        #1;
        release dut.hdr_count_q;
        m_count    = 16'hFFFE;
        deliveries = 16'hFFFE;
        drive_frame(1'b1, 1'b0, 20, 0, 32'h00000000);
        consume(1);
        chk("wrap_ffff", 64'(bus.hdr_count), 64'hFFFF);
        drive_frame(1'b0, 1'b0, 20, 0, 32'h00000100);
        consume(1);
        chk("wrap_zero", 64'(bus.hdr_count), 64'h0000);

        // random frames of every length class
        for (int f = 0; f < 30; f++) begin
            int kind;
            int n;
            kind = $urandom_range(0, 3);
            if (kind <= 1)      n = WC;
            else if (kind == 2) n = $urandom_range(1, WC - 1);
            else                n = $urandom_range(WC + 1, WC + 4);
            drive_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), n,
                        $urandom_range(0, 2), $urandom);
            if (n == WC) consume($urandom_range(0, 3));
            else repeat ($urandom_range(1, 3)) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/header_word_loader.md
Name: header_word_loader

Overview:
- Collects a block header arriving as a stream of WORD_WIDTH-bit words and optionally byte-swaps each word to correct endianness.
- Packs the words into one WORD_COUNT*WORD_WIDTH header register and presents it to the hashing core with a valid/ready handshake.
- Sits between the AXI-side header FIFO and the miner core. It is the only sequencer of the byte-swap datapath.
- Detects framing errors (short or long frames) and recovers without stalling the pipeline.

Parameters:
- WORD_WIDTH, 32, bits per stream word; must be a multiple of 8.
- WORD_COUNT, 20, words per header (20 x 32 = 640-bit header).
- CNT_WIDTH, 5, width of the word counter; must satisfy 2**CNT_WIDTH >= WORD_COUNT.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- swap_en  in  1  1 = byte-swap each word; sampled with the first word of a frame.
- s_data  in  WORD_WIDTH  stream word.
- s_valid  in  1  s_data valid.
- s_last  in  1  marks the final word of a frame.
- s_ready  out  1  loader accepts a word this cycle.
- hdr_data  out  WORD_WIDTH*WORD_COUNT  assembled header; word 0 in the MSBs.
- hdr_valid  out  1  hdr_data complete and stable.
- hdr_ready  in  1  core consumes the header.
- err_short  out  1  one-cycle pulse: s_last arrived before word WORD_COUNT-1.
- err_long  out  1  one-cycle pulse: word WORD_COUNT-1 arrived without s_last.
- hdr_count  out  16  number of headers delivered; wraps 0xFFFF -> 0.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset state: FILL; cnt=0; s_ready=0 during reset, 1 in the first cycle after reset; hdr_valid=0; err_short=0; err_long=0; hdr_count=0; hdr_data=0; latched swap=0.
- Accept condition: a word is accepted when s_valid && s_ready.
- FILL state:
  - s_ready=1.
  - On accept with cnt==0: latch swap_en for the whole frame. The first word uses the live swap_en value.
  - Each accepted word is byte-reversed if swap is set (byte i <- byte WORD_WIDTH/8-1-i), else passed through.
  - The result is written to hdr_data[(WORD_COUNT-cnt)*WORD_WIDTH-1 -: WORD_WIDTH], then cnt increments.
- FILL, accept with s_last and cnt<WORD_COUNT-1:
  - err_short pulses the next cycle.
  - cnt=0 and the partial header is discarded; hdr_data is not cleared.
  - Stay in FILL.
- FILL, accept with cnt==WORD_COUNT-1 and s_last: go to HOLD. hdr_valid=1 in the next cycle (1-cycle latency from the last word).
- FILL, accept with cnt==WORD_COUNT-1 and !s_last:
  - err_long pulses the next cycle.
  - Go to DRAIN; the header is not delivered.
- DRAIN state:
  - s_ready=1; words are discarded and hdr_data is untouched.
  - On accept with s_last: go to FILL with cnt=0.
- HOLD state:
  - s_ready=0; hdr_valid=1; hdr_data held stable.
  - On hdr_ready: hdr_count increments, hdr_valid=0 and cnt=0 in the next cycle, state returns to FILL.
  - This gives a mandatory one-cycle bubble: s_ready rises the cycle after the handshake.
- hdr_ready while not in HOLD is ignored.
- s_valid may drop mid-frame for any number of cycles; the frame simply pauses. s_data is ignored when s_valid=0.
- Reset mid-frame or during HOLD/DRAIN: everything returns to the reset state; the partial frame is lost and no error pulse is raised.
- WORD_COUNT==1: a single word with s_last goes directly to HOLD.

Decomposition:
- Shared package (header): state encodings FILL=2'd0, HOLD=2'd1, DRAIN=2'd2; BYTE_WIDTH=8; default header geometry constants (20 words, 32 bits).
- Sub-module: one instance of the existing swap_endian (UNIT_WIDTH=8, UNIT_COUNT=WORD_WIDTH/8) on s_data.
- A mux selects between the swapped and raw word using the latched swap (the live swap_en on word 0).
- FSM, counter and packing register stay in this module.

Test Plan:
- Nominal frame, swap: swap_en=1; feed 20 words 0x01020304+k (k=0..19) with s_last on word 19 -> hdr_valid=1 one cycle after word 19; hdr_data[639:608]=0x04030201; hdr_data[31:0]=0x17030201; hdr_count=1 after hdr_ready.
- Nominal frame, no swap, with gaps: swap_en=0; insert 3 idle cycles between every word -> hdr_data[639:608]=0x01020304.
- swap_en latching: swap_en set for word 0 only -> all 20 words swapped.
- Short frame: s_last on word 5 -> err_short pulses once; next 20-word frame is delivered correctly and hdr_count increments by 1 only.
- Long frame: 23 words, s_last on word 22 -> err_long pulses once, words 20..22 are absorbed in DRAIN, no hdr_valid; next frame is delivered.
- Backpressure and reset:
  - Hold hdr_ready=0 for 10 cycles -> s_ready=0, hdr_data stable throughout.
  - Raise hdr_ready -> s_ready returns 1 cycle after the handshake.
  - Assert rst at word 7 of a frame -> reset outputs, then a clean 20-word frame is delivered.
- hdr_count wrap: preload via 65536 deliveries (or force) -> count goes 0xFFFF -> 0x0000.
